// File: rtl/weight_loader.sv
// Weight-memory feeder: takes a neuron-select command, then streams num_weights words
// into that neuron's memory. Optional checksum output under WEIGHT_LOADER_CHECKSUM_EN.
module weight_loader #(
  parameter int data_width    = 16,
  parameter int address_width = 10,
  parameter int num_weights   = 784,
  parameter int num_neurons   = 30,
  parameter int sel_width     = 5,
  parameter int layer_no      = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [sel_width-1:0]     cmd_neuron,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [data_width-1:0]    s_data,
  input  logic                     s_last,
  output logic [num_neurons-1:0]   write_en,
  output logic [address_width-1:0] weight_address_w,
  output logic [data_width-1:0]    weight_in,
  output logic                     load_done,
  output logic                     load_err
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  ,
  output logic [data_width+address_width-1:0] load_sum
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [address_width-1:0] LastIdx    = address_width'(num_weights - 1);
  localparam logic [31:0]              NumNeurons = 32'(num_neurons);
  localparam logic [num_neurons-1:0]   OneBit     = {{(num_neurons-1){1'b0}}, 1'b1};

  state_t                   state_q, state_d;
  logic [sel_width-1:0]     neuron_q, neuron_d;
  logic [address_width-1:0] cnt_q, cnt_d;
  logic [num_neurons-1:0]   we_q, we_d;
  logic [address_width-1:0] addr_q, addr_d;
  logic [data_width-1:0]    data_q, data_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     cmd_ready_q, cmd_ready_d;
  logic                     s_ready_q, s_ready_d;

  logic accept_s;
  logic beat_s;
  logic in_range_s;

  assign accept_s   = cmd_valid & cmd_ready_q;
  assign beat_s     = s_valid & s_ready_q;
  assign in_range_s = (32'(cmd_neuron) < NumNeurons);

  // Next-state and registered-output decode
  always_comb begin
    state_d  = state_q;
    neuron_d = neuron_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    we_d     = '0;
    addr_d   = addr_q;
    data_d   = data_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          neuron_d = cmd_neuron;
          cnt_d    = '0;
          if (in_range_s) begin
            err_d   = 1'b0;
            state_d = LOAD;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (beat_s) begin
          we_d   = OneBit << neuron_q;
          addr_d = cnt_q;
          data_d = s_data;
          // Counter stops at the final index so no out-of-range address is ever driven.
          if (cnt_q == LastIdx) begin
            err_d   = err_q | ~s_last;
            state_d = DONE;
          end else if (s_last) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + {{(address_width-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = LOAD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    done_d      = (state_d == DONE);
    cmd_ready_d = (state_d == IDLE);
    s_ready_d   = (state_d == LOAD);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      neuron_q    <= '0;
      cnt_q       <= '0;
      we_q        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      s_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      neuron_q    <= neuron_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cmd_ready_q <= cmd_ready_d;
      s_ready_q   <= s_ready_d;
    end
  end

  assign cmd_ready        = cmd_ready_q;
  assign s_ready          = s_ready_q;
  assign write_en         = we_q;
  assign weight_address_w = addr_q;
  assign weight_in        = data_q;
  assign load_done        = done_q;
  assign load_err         = err_q;

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [data_width+address_width-1:0] sum_q, sum_d;

  // Running sum of written words, restarted on each accepted command
  always_comb begin
    sum_d = sum_q;
    if (accept_s) begin
      sum_d = '0;
    end else if (state_q == LOAD && beat_s) begin
      sum_d = sum_q + (data_width+address_width)'(s_data);
    end else begin
      sum_d = sum_q;
    end
  end

  // Checksum register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign load_sum = sum_q;
`endif

endmodule

// File: tb/tb_weight_loader.sv
// Self-checking bench for weight_loader (num_weights=4, num_neurons=3, sel_width=2).
// Checksum checks are compiled in when WEIGHT_LOADER_CHECKSUM_EN is defined.
module tb_weight_loader;
  localparam int DW = 16;
  localparam int AW = 2;
  localparam int NW = 4;
  localparam int NN = 3;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [SW-1:0] cmd_neuron;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic [NN-1:0] write_en;
  logic [AW-1:0] weight_address_w;
  logic [DW-1:0] weight_in;
  logic          load_done;
  logic          load_err;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [DW+AW-1:0] load_sum;
`endif

  weight_loader #(
    .data_width(DW), .address_width(AW), .num_weights(NW),
    .num_neurons(NN), .sel_width(SW), .layer_no(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_neuron(cmd_neuron), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .write_en(write_en), .weight_address_w(weight_address_w),
    .weight_in(weight_in), .load_done(load_done), .load_err(load_err)
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    , .load_sum(load_sum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int neuron;
    int n;
    int a;
    int d;
  } wr_t;

  typedef struct {
    int   neuron;
    int   last_pos;   // index carrying s_last; >= NW means never
    int   gap;        // 0 none, 1 one idle cycle between beats, 2 random idles
    logic exp_err;
    int   exp_nw;
  } vec_t;

  int  total = 0;
  int  bad   = 0;
  int  viol  = 0;
  wr_t got_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Write monitor: logs every write and counts framing violations
  always @(posedge clk) begin
    #1;
    if (write_en != '0) begin
      wr_t w;
      if ($countones(write_en) != 1 || int'(weight_address_w) >= NW) viol++;
      w.neuron = 0;
      for (int b = NN - 1; b >= 0; b--) if (write_en[b]) w.neuron = b;
      w.n = 0;
      w.a = int'(weight_address_w);
      w.d = int'(weight_in);
      got_q.push_back(w);
    end
  end

  // Reference model: plain rules for how much of a burst lands in memory
  function automatic int model_nw(input int neuron, input int last_pos);
    if (neuron >= NN) return 0;
    return (last_pos < NW) ? last_pos + 1 : NW;
  endfunction

  function automatic logic model_err(input int neuron, input int last_pos);
    return (neuron >= NN) || (last_pos != NW - 1);
  endfunction

  task automatic accept_cmd(input int neuron, output bit ok);
    ok = 1'b0;
    cmd_neuron = SW'(neuron);
    cmd_valid  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      chk("cmd_accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic send_beat(input int neuron, input int i, input logic [DW-1:0] d,
                           input logic last, output bit ok);
    logic [NN-1:0] oh;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    for (int k = 0; k < 10; k++) begin
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      chk("beat_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk); #1;
      oh = '0;
      oh[neuron] = 1'b1;
      chk("beat_write_en", 32'(write_en), 32'(oh));
      chk("beat_addr", 32'(weight_address_w), 32'(i));
      chk("beat_data", 32'(weight_in), 32'(d));
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic run_burst(input int neuron, input int last_pos, input int gap,
                           input logic [DW-1:0] w[NW], input logic exp_err, input int exp_nw);
    bit ok;
    int sum = 0;
    got_q.delete();
    accept_cmd(neuron, ok);
    if (!ok) return;
    chk("err_after_accept", 32'(load_err), 32'(neuron >= NN));
    for (int i = 0; i < exp_nw; i++) begin
      int g;
      g = (gap == 1 && i > 0) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int j = 0; j < g; j++) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
        chk("gap_write_en", 32'(write_en), 32'd0);
        if (i > 0) chk("gap_addr_hold", 32'(weight_address_w), 32'(i - 1));
      end
      send_beat(neuron, i, w[i], logic'(i == last_pos), ok);
      if (!ok) return;
      sum += int'(w[i]);
    end
    chk("done_pulse", 32'(load_done), 32'd1);
    chk("done_err", 32'(load_err), 32'(exp_err));
    chk("done_s_ready", 32'(s_ready), 32'd0);
    chk("done_cmd_ready", 32'(cmd_ready), 32'd0);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    chk("load_sum", 32'(load_sum), 32'(sum));
`endif
    @(posedge clk); #1;
    chk("after_done_low", 32'(load_done), 32'd0);
    chk("after_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("after_err_sticky", 32'(load_err), 32'(exp_err));
    chk("after_write_en", 32'(write_en), 32'd0);
    chk("write_count", 32'(got_q.size()), 32'(exp_nw));
    for (int i = 0; i < exp_nw && i < got_q.size(); i++) begin
      chk("log_neuron", 32'(got_q[i].neuron), 32'(neuron));
      chk("log_addr", 32'(got_q[i].a), 32'(i));
      chk("log_data", 32'(got_q[i].d), 32'(w[i]));
    end
  endtask

  initial begin
    vec_t          tbl[6];
    logic [DW-1:0] w[NW];
    bit            ok;

    tbl[0] = '{neuron: 2, last_pos: 3, gap: 0, exp_err: 1'b0, exp_nw: 4};
    tbl[1] = '{neuron: 2, last_pos: 3, gap: 1, exp_err: 1'b0, exp_nw: 4};
    tbl[2] = '{neuron: 3, last_pos: 3, gap: 0, exp_err: 1'b1, exp_nw: 0};
    tbl[3] = '{neuron: 1, last_pos: 1, gap: 0, exp_err: 1'b1, exp_nw: 2};
    tbl[4] = '{neuron: 0, last_pos: 3, gap: 1, exp_err: 1'b0, exp_nw: 4};
    tbl[5] = '{neuron: 1, last_pos: 9, gap: 0, exp_err: 1'b1, exp_nw: 4};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_neuron = '0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_write_en", 32'(write_en), 32'd0);
    chk("rst_addr", 32'(weight_address_w), 32'd0);
    chk("rst_data", 32'(weight_in), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    chk("rst_sum", 32'(load_sum), 32'd0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < NW; i++) w[i] = DW'(17 * (i + 1));
    foreach (tbl[t])
      run_burst(tbl[t].neuron, tbl[t].last_pos, tbl[t].gap, w, tbl[t].exp_err, tbl[t].exp_nw);

    // Reset after the second beat of a burst
    got_q.delete();
    accept_cmd(1, ok);
    if (ok) begin
      send_beat(1, 0, 16'h0A0A, 1'b0, ok);
      send_beat(1, 1, 16'h0B0B, 1'b0, ok);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("midrst_write_en", 32'(write_en), 32'd0);
      chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("midrst_s_ready", 32'(s_ready), 32'd0);
      chk("midrst_done", 32'(load_done), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("midrst_no_done", 32'(load_done), 32'd0);
      run_burst(0, 3, 0, w, 1'b0, 4);
    end

    for (int r = 0; r < 25; r++) begin
      int n, lp;
      n  = int'($urandom_range(0, NN));
      lp = int'($urandom_range(0, NW));
      for (int i = 0; i < NW; i++) w[i] = DW'($urandom);
      run_burst(n, lp, 2, w, model_err(n, lp), model_nw(n, lp));
    end

    chk("onehot_addr_violations", 32'(viol), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
